sysctrl_param: RTL and testbench
================================

// Module: sysctrl_param
// PURPOSE
//  Parametrised MCU system-control slave; sits on the MCU byte-stream link beside the HID/SD blocks.
//  Decodes framed commands: status/ID, LEDs, RGB colour, buttons, generic config-register writes,
//  interrupt control, coldboot and config readback. Owns the power-on reset timeout.
//  Config slots are a flat, id-indexed register file, so new cores need no per-letter edits.
// PARAMETERS
//  CORE_ID        8'h05          core id returned by CMD 0, byte 3
//  NUM_CFG        16             number of config slots (1..64)
//  CFG_W          4              config slot width in bits (1..8)
//  ID_BASE        8'h41          config id that maps to slot 0 ('A')
//  CFG_DEFAULTS   {NUM_CFG*CFG_W{1'b0}}  reset value of cfg_flat
//  RESET_TIMEOUT  80_000_000     clk cycles before self-release of system_reset
//  TIMEOUT_COLOR  24'h000202     colour driven when the timeout expires
// PORTS
//  clk             in   1             system clock
//  reset           in   1             synchronous, active-high
//  data_in_strobe  in   1             one-cycle pulse per received byte
//  data_in_start   in   1             qualifies the strobe: first (command) byte of a frame
//  data_in         in   8             received byte
//  data_out        out  8             response byte, registered
//  int_out_n       out  1             active-low interrupt to the MCU
//  int_in          in   8             peripheral interrupt requests, bits 7:1 used (bit 0 reserved)
//  int_ack         out  8             one-cycle acknowledge pulses to peripherals
//  buttons         in   2             board buttons
//  leds            out  2             MCU-controlled LEDs
//  color           out  24            RGB LED colour
//  system_reset    out  2             core reset request
//  cold_boot       out  1             power-on flag not yet read by the MCU
//  cfg_flat        out  NUM_CFG*CFG_W config slots; slot k = [k*CFG_W +: CFG_W]
//  cfg_wr          out  NUM_CFG       one-cycle pulse on slot k when slot k is written
// BEHAVIOUR
//  Reset values:
//   data_out=0, leds=0, color=0, system_reset=3, cold_boot=1, sys_int=1, int_ack=0,
//   int_pend=0, cfg_flat=CFG_DEFAULTS, cfg_wr=0, timeout counter=RESET_TIMEOUT, idx=0.
//  Framing:
//   Strobe with start: cmd<=data_in, idx<=1.
//   Strobe without start, idx!=0: process byte idx, then idx increments and saturates at 15.
//   idx=0: non-start bytes are ignored.
//   data_out updates on the same strobe, in the cycle after it.
//  CMD 0, status: bytes 1/2/3 -> data_out = 5C/42/CORE_ID; bytes 4 and later -> 00.
//  CMD 1, LEDs: byte 1 -> leds = data_in[1:0].
//  CMD 2, colour: bytes 1/2/3 -> color[15:8]/[7:0]/[23:16] = bit-reversed data_in.
//  CMD 3, buttons: each byte -> data_out = {6'b0, buttons}.
//  CMD 4, config write: byte 1 = id, byte 2 = value.
//   id=="R": system_reset = value[1:0]; timeout counter cleared (cancelled permanently).
//   else slot = id-ID_BASE (8-bit); if id>=ID_BASE and slot<NUM_CFG:
//    cfg slot = value[CFG_W-1:0], and cfg_wr[slot] pulses in the following cycle.
//   Out-of-range id: ignored. Bytes 3 and later: ignored.
//  CMD 5, interrupts:
//   each byte -> data_out = {int_pend[7:1], sys_int}.
//   byte 1 -> int_ack = data_in for exactly one cycle, in the next cycle.
//   int_ack[0] clears sys_int; int_ack[i] clears int_pend[i].
//  Interrupt pending (new behaviour): int_pend[i] is sticky.
//   Set while int_in[i]=1; cleared only by int_ack[i].
//   Set and ack in the same cycle -> stays set.
//   int_out_n = ~(|int_pend[7:1] | sys_int).
//  CMD 6, coldboot: each byte -> data_out = {7'b0, cold_boot}; byte 1 also clears cold_boot.
//  Timeout: while the counter is nonzero, decrement by 1 per clk.
//   On the 1->0 step: system_reset=0 and color=TIMEOUT_COLOR.
//   A CMD 4 "R" write on the same cycle wins and cancels the timeout.
//  Unknown command: bytes are consumed and data_out is unchanged.
//  A start strobe mid-frame aborts the current frame; partial colour/config writes already
//   applied are kept.
//  reset asserted mid-frame: everything returns to its reset values, including the timeout.
// CONFIGURATION
//  SYSCTRL_READBACK_EN defined:
//   CMD 7, config readback: byte 1 = id.
//   Bytes 2 and later -> data_out = zero-extended slot value, or FF if the id is out of range.
//   Id "R" returns {6'b0, system_reset}.
//  SYSCTRL_READBACK_EN undefined: CMD 7 is an unknown command (data_out unchanged); no readback mux.
// TESTING
//  1. Status: reset, then frame 00,xx,xx,xx,xx -> data_out 5C,42,05,00 after bytes 1-4.
//  2. Config (ID_BASE=41, NUM_CFG=16, CFG_W=4):
//     04,43,0B -> slot 2 = B and cfg_wr=0004 for one cycle.
//     04,60,07 -> no change, no cfg_wr pulse.
//  3. Timeout, RESET_TIMEOUT=10, no traffic -> system_reset 3->0 and color=000202 at cycle 10.
//     Rerun with 04,52,00 at cycle 5 -> system_reset=0 at cycle 5 and color stays 000000.
//  4. Interrupts: pulse int_in[3] for 1 cycle -> int_out_n stays 0.
//     Frame 05,09 -> data_out=09 (with sys_int=1), int_ack=09 for one cycle,
//     then int_out_n=1 once int_in=0.
//  5. Colour: 02,80,01,FF -> color=FF0180. Then 06,xx -> data_out=01, and cold_boot=0 afterwards.
//  6. Readback (macro defined): 04,41,05 then 07,41,xx -> data_out=05. 07,7F,xx -> FF.
//     Macro undefined: 07,41,xx -> data_out unchanged.

Source files
------------

// File: rtl/sysctrl_param_if.sv
// ============================================================================
//  Module   : sysctrl_param_if
//  Purpose  : MCU byte-stream link between the MCU bridge and sysctrl_param.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface sysctrl_param_if;
   logic       data_in_strobe;
   logic       data_in_start;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       int_out_n;

   modport master (
      output data_in_strobe,
      output data_in_start,
      output data_in,
      input  data_out,
      input  int_out_n
   );

   modport slave (
      input  data_in_strobe,
      input  data_in_start,
      input  data_in,
      output data_out,
      output int_out_n
   );
endinterface

`default_nettype wire

// File: rtl/sysctrl_param.sv
// ============================================================================
//  Module   : sysctrl_param
//  Purpose  : MCU system-control slave (status, LEDs, colour, buttons, config
//             slots, interrupts, coldboot, power-on timeout). Optional config
//             readback (CMD 7) is enabled by defining SYSCTRL_READBACK_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sysctrl_param #(
   parameter logic [7:0]                 CORE_ID       = 8'h05,
   parameter int                         NUM_CFG       = 16,
   parameter int                         CFG_W         = 4,
   parameter logic [7:0]                 ID_BASE       = 8'h41,
   parameter logic [NUM_CFG*CFG_W-1:0]   CFG_DEFAULTS  = '0,
   parameter int                         RESET_TIMEOUT = 80_000_000,
   parameter logic [23:0]                TIMEOUT_COLOR = 24'h000202
) (
   input  wire logic                     clk,
   input  wire logic                     reset,
   sysctrl_param_if.slave                link,
   input  wire logic [7:0]               int_in,
   output logic [7:0]                    int_ack,
   input  wire logic [1:0]               buttons,
   output logic [1:0]                    leds,
   output logic [23:0]                   color,
   output logic [1:0]                    system_reset,
   output logic                          cold_boot,
   output logic [NUM_CFG*CFG_W-1:0]      cfg_flat,
   output logic [NUM_CFG-1:0]            cfg_wr
);

   localparam int             TO_W    = (RESET_TIMEOUT > 1) ? $clog2(RESET_TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_INIT = TO_W'(RESET_TIMEOUT);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
   localparam logic [7:0]     ID_R    = 8'h52;

   localparam logic [7:0] CMD_STATUS  = 8'd0;
   localparam logic [7:0] CMD_LED     = 8'd1;
   localparam logic [7:0] CMD_COLOR   = 8'd2;
   localparam logic [7:0] CMD_BUTTONS = 8'd3;
   localparam logic [7:0] CMD_CFG     = 8'd4;
   localparam logic [7:0] CMD_INT     = 8'd5;
   localparam logic [7:0] CMD_COLD    = 8'd6;
`ifdef SYSCTRL_READBACK_EN
   localparam logic [7:0] CMD_READ    = 8'd7;
`endif

   logic [7:0]         r_cmd;
   logic [3:0]         r_idx;
   logic [7:0]         r_cfg_id;
   logic [7:0]         r_data_out;
   logic [1:0]         r_leds;
   logic [23:0]        r_color;
   logic [1:0]         r_sys_reset;
   logic               r_cold_boot;
   logic               r_sys_int;
   logic [7:1]         r_int_pend;
   logic [7:0]         r_int_ack;
   logic [TO_W-1:0]    r_tmo;
   logic [CFG_W-1:0]   r_cfg [NUM_CFG];
   logic [NUM_CFG-1:0] r_cfg_wr;

   logic               w_byte;
   logic [7:0]         w_slot;
   logic               w_slot_ok;
   logic               w_cfg_write;
   logic               w_r_write;
   logic [NUM_CFG-1:0] w_wr_vec;
   logic [7:0]         w_dout;
   logic               w_unused_ok;

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   assign w_unused_ok = int_in[0];

   // Payload byte of an open frame; r_idx==0 means no frame has been started.
   always_comb begin
      w_byte      = link.data_in_strobe && !link.data_in_start && (r_idx != 4'd0);
      w_slot      = r_cfg_id - ID_BASE;
      w_slot_ok   = (r_cfg_id >= ID_BASE) && (32'(w_slot) < 32'(NUM_CFG));
      w_r_write   = w_byte && (r_cmd == CMD_CFG) && (r_idx == 4'd2) && (r_cfg_id == ID_R);
      w_cfg_write = w_byte && (r_cmd == CMD_CFG) && (r_idx == 4'd2) && (r_cfg_id != ID_R)
                    && w_slot_ok;
      for (int k = 0; k < NUM_CFG; k++) begin
         w_wr_vec[k] = w_cfg_write && (w_slot == 8'(k));
      end
   end

`ifdef SYSCTRL_READBACK_EN
   logic [7:0] w_rb;

   always_comb begin
      w_rb = 8'hFF;
      if (r_cfg_id == ID_R) begin
         w_rb = {6'b0, r_sys_reset};
      end else if (w_slot_ok) begin
         w_rb = '0;
         for (int k = 0; k < NUM_CFG; k++) begin
            if (w_slot == 8'(k)) w_rb[CFG_W-1:0] = r_cfg[k];
         end
      end
   end
`endif

   always_comb begin
      w_dout = r_data_out;
      if (w_byte) begin
         case (r_cmd)
            CMD_STATUS: begin
               case (r_idx)
                  4'd1:    w_dout = 8'h5C;
                  4'd2:    w_dout = 8'h42;
                  4'd3:    w_dout = CORE_ID;
                  default: w_dout = 8'h00;
               endcase
            end
            CMD_BUTTONS: w_dout = {6'b0, buttons};
            CMD_INT:     w_dout = {r_int_pend, r_sys_int};
            CMD_COLD:    w_dout = {7'b0, r_cold_boot};
`ifdef SYSCTRL_READBACK_EN
            CMD_READ:    if (r_idx >= 4'd2) w_dout = w_rb;
`endif
            default:     w_dout = r_data_out;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cmd       <= '0;
         r_idx       <= '0;
         r_cfg_id    <= '0;
         r_data_out  <= '0;
         r_leds      <= '0;
         r_color     <= '0;
         r_sys_reset <= 2'd3;
         r_cold_boot <= 1'b1;
         r_sys_int   <= 1'b1;
         r_int_pend  <= '0;
         r_int_ack   <= '0;
         r_tmo       <= TO_INIT;
         r_cfg_wr    <= '0;
         for (int k = 0; k < NUM_CFG; k++) r_cfg[k] <= CFG_DEFAULTS[k*CFG_W +: CFG_W];
      end else begin
         r_data_out <= w_dout;
         r_int_ack  <= '0;
         r_cfg_wr   <= w_wr_vec;
         r_int_pend <= int_in[7:1] | (r_int_pend & ~r_int_ack[7:1]);
         if (r_int_ack[0]) r_sys_int <= 1'b0;

         // Timeout expiry loses to an "R" write landing on the same cycle.
         if (r_tmo != '0) begin
            r_tmo <= r_tmo - TO_ONE;
            if ((r_tmo == TO_ONE) && !w_r_write) begin
               r_sys_reset <= 2'd0;
               r_color     <= TIMEOUT_COLOR;
            end
         end

         for (int k = 0; k < NUM_CFG; k++) begin
            if (w_wr_vec[k]) r_cfg[k] <= link.data_in[CFG_W-1:0];
         end

         if (link.data_in_strobe && link.data_in_start) begin
            r_cmd <= link.data_in;
            r_idx <= 4'd1;
         end else if (w_byte) begin
            if (r_idx != 4'hF) r_idx <= r_idx + 4'd1;
            case (r_cmd)
               CMD_LED: if (r_idx == 4'd1) r_leds <= link.data_in[1:0];
               CMD_COLOR: begin
                  case (r_idx)
                     4'd1:    r_color[15:8]  <= rev8(link.data_in);
                     4'd2:    r_color[7:0]   <= rev8(link.data_in);
                     4'd3:    r_color[23:16] <= rev8(link.data_in);
                     default: ;
                  endcase
               end
               CMD_CFG: begin
                  if (r_idx == 4'd1) r_cfg_id <= link.data_in;
                  if (w_r_write) begin
                     r_sys_reset <= link.data_in[1:0];
                     r_tmo       <= '0;
                  end
               end
               CMD_INT:  if (r_idx == 4'd1) r_int_ack <= link.data_in;
               CMD_COLD: if (r_idx == 4'd1) r_cold_boot <= 1'b0;
`ifdef SYSCTRL_READBACK_EN
               CMD_READ: if (r_idx == 4'd1) r_cfg_id <= link.data_in;
`endif
               default: ;
            endcase
         end
      end
   end

   generate
      for (genvar k = 0; k < NUM_CFG; k++) begin : g_flat
         assign cfg_flat[k*CFG_W +: CFG_W] = r_cfg[k];
      end
   endgenerate

   assign link.data_out  = r_data_out;
   assign link.int_out_n = ~((|r_int_pend) | r_sys_int);
   assign int_ack        = r_int_ack;
   assign leds           = r_leds;
   assign color          = r_color;
   assign system_reset   = r_sys_reset;
   assign cold_boot      = r_cold_boot;
   assign cfg_wr         = r_cfg_wr;

endmodule

`default_nettype wire

// File: tb/tb_sysctrl_param.sv
// ============================================================================
//  Module   : tb_sysctrl_param
//  Purpose  : Directed, scoreboard-checked bench for sysctrl_param.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sysctrl_param;
   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  int_in;
   logic [7:0]  int_ack;
   logic [1:0]  buttons;
   logic [1:0]  leds;
   logic [23:0] color;
   logic [1:0]  system_reset;
   logic        cold_boot;
   logic [63:0] cfg_flat;
   logic [15:0] cfg_wr;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  sb [$];
   logic [7:0]  exp_dout;

   always #5 clk = ~clk;

   sysctrl_param_if link ();

   sysctrl_param #(.RESET_TIMEOUT(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .link         (link),
      .int_in       (int_in),
      .int_ack      (int_ack),
      .buttons      (buttons),
      .leds         (leds),
      .color        (color),
      .system_reset (system_reset),
      .cold_boot    (cold_boot),
      .cfg_flat     (cfg_flat),
      .cfg_wr       (cfg_wr)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every accepted strobe yields one data_out expectation.
   initial forever begin
      @(posedge clk);
      if (link.data_in_strobe && !reset) begin
         #1;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL data_out: got %0h with no expectation queued", link.data_out);
         end else begin
            chk("data_out", {56'b0, link.data_out}, {56'b0, sb.pop_front()});
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input bit st, input logic [7:0] b,
                       input bit upd = 1'b0, input logic [7:0] e = 8'h00);
      link.data_in_strobe = 1'b1;
      link.data_in_start  = st;
      link.data_in        = b;
      if (upd) exp_dout = e;
      sb.push_back(exp_dout);
      @(negedge clk);
      link.data_in_strobe = 1'b0;
      link.data_in_start  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb.delete();
      exp_dout = 8'h00;
      idle(3);
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      link.data_in_strobe = 1'b0;
      link.data_in_start  = 1'b0;
      link.data_in        = 8'h00;
      int_in  = 8'h00;
      buttons = 2'b00;
      reset   = 1'b1;
      idle(3);

      chk("rst data_out", {56'b0, link.data_out}, 64'h0);
      chk("rst leds", {62'b0, leds}, 64'h0);
      chk("rst color", {40'b0, color}, 64'h0);
      chk("rst system_reset", {62'b0, system_reset}, 64'h3);
      chk("rst cold_boot", {63'b0, cold_boot}, 64'h1);
      chk("rst int_out_n", {63'b0, link.int_out_n}, 64'h0);
      chk("rst int_ack", {56'b0, int_ack}, 64'h0);
      chk("rst cfg_wr", {48'b0, cfg_wr}, 64'h0);
      chk("rst cfg_flat", cfg_flat, 64'h0);

      // Timeout with no traffic: expires on the 10th edge after release.
      do_reset();
      repeat (9) @(posedge clk);
      #1;
      chk("tmo before", {62'b0, system_reset}, 64'h3);
      @(posedge clk);
      #1;
      chk("tmo sysrst", {62'b0, system_reset}, 64'h0);
      chk("tmo color", {40'b0, color}, 64'h000202);
      @(negedge clk);

      // No frame open: non-start byte ignored.
      send(1'b0, 8'h01);
      chk("idx0 leds", {62'b0, leds}, 64'h0);

      // "R" write at cycle 5 cancels the timeout.
      do_reset();
      idle(2);
      send(1'b1, 8'h04); send(1'b0, 8'h52); send(1'b0, 8'h00);
      chk("R5 sysrst", {62'b0, system_reset}, 64'h0);
      idle(10);
      chk("R5 color", {40'b0, color}, 64'h0);

      // "R" write on the same cycle as the 1->0 step wins.
      do_reset();
      idle(7);
      send(1'b1, 8'h04); send(1'b0, 8'h52); send(1'b0, 8'h02);
      chk("R10 sysrst", {62'b0, system_reset}, 64'h2);
      chk("R10 color", {40'b0, color}, 64'h0);
      idle(5);
      chk("R10 later", {62'b0, system_reset}, 64'h2);

      // Status, including saturation of the byte index.
      send(1'b1, 8'h00);
      send(1'b0, 8'hAA, 1, 8'h5C);
      send(1'b0, 8'hAA, 1, 8'h42);
      send(1'b0, 8'hAA, 1, 8'h05);
      send(1'b0, 8'hAA, 1, 8'h00);
      for (int i = 0; i < 14; i++) send(1'b0, 8'hAA, 1, 8'h00);

      // LEDs: only byte 1 counts.
      send(1'b1, 8'h01); send(1'b0, 8'h03);
      chk("leds 3", {62'b0, leds}, 64'h3);
      send(1'b1, 8'h01); send(1'b0, 8'h02); send(1'b0, 8'h01);
      chk("leds 2", {62'b0, leds}, 64'h2);

      // Config slots.
      send(1'b1, 8'h04); send(1'b0, 8'h43); send(1'b0, 8'h0B);
      chk("cfg_wr slot2", {48'b0, cfg_wr}, 64'h0004);
      chk("cfg slot2", cfg_flat, 64'h0000_0000_0000_0B00);
      idle(1);
      chk("cfg_wr clear", {48'b0, cfg_wr}, 64'h0);
      send(1'b1, 8'h04); send(1'b0, 8'h60); send(1'b0, 8'h07);
      chk("cfg_wr oob", {48'b0, cfg_wr}, 64'h0);
      send(1'b1, 8'h04); send(1'b0, 8'h50); send(1'b0, 8'h0C);
      chk("cfg_wr slot15", {48'b0, cfg_wr}, 64'h8000);
      send(1'b1, 8'h04); send(1'b0, 8'h51); send(1'b0, 8'h0D);
      chk("cfg_wr slot16", {48'b0, cfg_wr}, 64'h0);
      send(1'b1, 8'h04); send(1'b0, 8'h40); send(1'b0, 8'h0E);
      send(1'b1, 8'h04); send(1'b0, 8'h41); send(1'b0, 8'hF5);
      send(1'b1, 8'h04); send(1'b0, 8'h42); send(1'b0, 8'h03); send(1'b0, 8'h09);
      chk("cfg all", cfg_flat, 64'hC000_0000_0000_0B35);

`ifdef SYSCTRL_READBACK_EN
      send(1'b1, 8'h07); send(1'b0, 8'h41); send(1'b0, 8'h00, 1, 8'h05);
      send(1'b1, 8'h07); send(1'b0, 8'h50); send(1'b0, 8'h00, 1, 8'h0C);
      send(1'b1, 8'h07); send(1'b0, 8'h7F); send(1'b0, 8'h00, 1, 8'hFF);
      send(1'b1, 8'h07); send(1'b0, 8'h52); send(1'b0, 8'h00, 1, 8'h02);
`else
      send(1'b1, 8'h07); send(1'b0, 8'h41); send(1'b0, 8'h00);
`endif

      // Unknown command leaves data_out alone.
      send(1'b1, 8'h09); send(1'b0, 8'hAA); send(1'b0, 8'hBB);

      // Buttons.
      buttons = 2'b10;
      send(1'b1, 8'h03); send(1'b0, 8'h00, 1, 8'h02);
      buttons = 2'b01;
      send(1'b0, 8'h00, 1, 8'h01);

      // Interrupts.
      int_in = 8'h08;
      idle(1);
      int_in = 8'h00;
      idle(1);
      chk("irq pending", {63'b0, link.int_out_n}, 64'h0);
      send(1'b1, 8'h05); send(1'b0, 8'h09, 1, 8'h09);
      chk("int_ack 09", {56'b0, int_ack}, 64'h09);
      idle(1);
      chk("int_ack pulse", {56'b0, int_ack}, 64'h0);
      chk("irq cleared", {63'b0, link.int_out_n}, 64'h1);
      int_in = 8'h20;
      idle(1);
      send(1'b1, 8'h05); send(1'b0, 8'h20, 1, 8'h20);
      chk("int_ack 20", {56'b0, int_ack}, 64'h20);
      idle(1);
      chk("irq held", {63'b0, link.int_out_n}, 64'h0);
      int_in = 8'h00;
      idle(1);
      chk("irq sticky", {63'b0, link.int_out_n}, 64'h0);
      send(1'b1, 8'h05); send(1'b0, 8'h20, 1, 8'h20);
      idle(1);
      chk("irq released", {63'b0, link.int_out_n}, 64'h1);

      // Colour, then an aborted colour frame followed by status.
      send(1'b1, 8'h02); send(1'b0, 8'h80); send(1'b0, 8'h01); send(1'b0, 8'hFF);
      chk("color", {40'b0, color}, 64'hFF0180);
      send(1'b1, 8'h02); send(1'b0, 8'h11);
      send(1'b1, 8'h00); send(1'b0, 8'h33, 1, 8'h5C);
      chk("color abort", {40'b0, color}, 64'hFF8880);

      // Coldboot flag reads once.
      send(1'b1, 8'h06); send(1'b0, 8'h00, 1, 8'h01);
      chk("cold_boot clr", {63'b0, cold_boot}, 64'h0);
      send(1'b1, 8'h06); send(1'b0, 8'h00, 1, 8'h00);

      idle(2);
      chk("sb drained", 64'(sb.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
